sumador_acumulador: RTL



---
 rtl/sumador_pkg.sv | 20 ++
 rtl/sumador_carry.sv | 22 ++
 rtl/sumador_acumulador.sv | 112 +++++++++++
 3 files changed

// File: rtl/sumador_pkg.sv
// Shared types and helpers for the signed accumulator.
package sumador_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_CLR  = 2'b11
    } op_t;

    localparam int unsigned LIMIT_W = 64;

    // Signed max (positive=1) or min (positive=0) for a given width, right-aligned in LIMIT_W bits.
    function automatic logic [LIMIT_W-1:0] sat_limit(input int unsigned width, input logic positive);
        logic [LIMIT_W-1:0] half;
        half = LIMIT_W'(1) << (width - 1);
        sat_limit = positive ? (half - LIMIT_W'(1)) : ~(half - LIMIT_W'(1));
    endfunction

endpackage

// File: rtl/sumador_carry.sv
// Combinational WIDTH-bit adder with carry-in, carry-out and signed overflow.
module sumador_carry #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum_c,
    output logic             cout_c,
    output logic             ovf_c
);

    logic [WIDTH:0] full;

    always_comb begin
        full   = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
        sum_c  = full[WIDTH-1:0];
        cout_c = full[WIDTH];
        ovf_c  = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/sumador_acumulador.sv
// Signed accumulator: LOAD/ADD/SUB/CLR with registered result, flags and op counter.
module sumador_acumulador
    import sumador_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter bit          SATURATE = 1'b0,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  op_t              op,
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] acc,
    output logic             out_valid,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             sticky_ovf,
    output logic [CNT_W-1:0] op_count
);

    logic [WIDTH-1:0] operand_c;
    logic             cin_c;
    logic [WIDTH-1:0] sum_c;
    logic             cout_c;
    logic             ovf_c;

    logic [WIDTH-1:0] acc_n;
    logic             carry_n;
    logic             ovf_n;
    logic             sticky_n;
    logic [CNT_W-1:0] cnt_n;

    // SUB reuses the single adder as acc + ~A + 1.
    assign operand_c = (op == OP_SUB) ? ~A : A;
    assign cin_c     = (op == OP_SUB);

    sumador_carry #(.WIDTH(WIDTH)) u_carry (
        .a      (acc),
        .b      (operand_c),
        .cin    (cin_c),
        .sum_c  (sum_c),
        .cout_c (cout_c),
        .ovf_c  (ovf_c)
    );

    // Next-state decode for an accepted op.
    always_comb begin
        acc_n    = acc;
        carry_n  = carry;
        ovf_n    = overflow;
        sticky_n = sticky_ovf;
        cnt_n    = op_count;
        case (op)
            OP_LOAD: begin
                acc_n   = A;
                carry_n = 1'b0;
                ovf_n   = 1'b0;
            end
            OP_ADD, OP_SUB: begin
                carry_n = (op == OP_SUB) ? ~cout_c : cout_c;
                ovf_n   = ovf_c;
                // On overflow the true result has the sign of the old accumulator.
                if (SATURATE && ovf_c) begin
                    acc_n = WIDTH'(sat_limit(WIDTH, ~acc[WIDTH-1]));
                end else begin
                    acc_n = sum_c;
                end
            end
            default: begin
                acc_n    = '0;
                carry_n  = 1'b0;
                ovf_n    = 1'b0;
                sticky_n = 1'b0;
                cnt_n    = '0;
            end
        endcase
        if (op != OP_CLR) begin
            sticky_n = sticky_ovf | ovf_n;
            if (op_count != {CNT_W{1'b1}}) begin
                cnt_n = op_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            out_valid  <= 1'b0;
            carry      <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
            negative   <= 1'b0;
            sticky_ovf <= 1'b0;
            op_count   <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                acc        <= acc_n;
                carry      <= carry_n;
                overflow   <= ovf_n;
                zero       <= (acc_n == '0);
                negative   <= acc_n[WIDTH-1];
                sticky_ovf <= sticky_n;
                op_count   <= cnt_n;
            end
        end
    end

endmodule
